// File: rtl/rx_phase_sync_slicer.sv
// Receive-side phase recovery: max-energy search over the OS polyphase branches,
// decimation at the chosen phase and sign slicing of the I/Q symbols.
module rx_phase_sync_slicer #(
  parameter int NB_INPUT  = 8,
  parameter int NBF_INPUT = 7,
  parameter int OS        = 4,
  parameter int LOG2_WIN  = 8,
  localparam int NB_PH    = $clog2(OS)
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic signed [NB_INPUT-1:0] i_sample_I,
  input  logic signed [NB_INPUT-1:0] i_sample_Q,
  input  logic                       i_phase_force_en,
  input  logic [NB_PH-1:0]           i_phase_force,
  output logic [NB_PH-1:0]           o_phase,
  output logic                       o_locked,
  output logic                       o_valid,
  output logic signed [NB_INPUT-1:0] o_sym_I,
  output logic signed [NB_INPUT-1:0] o_sym_Q,
  output logic                       o_bit_I,
  output logic                       o_bit_Q
);

  localparam int NB_ACC = NB_INPUT + 1 + LOG2_WIN;
  localparam int NB_E   = NB_INPUT + 1;
  localparam logic [NB_PH-1:0] CNT_LAST = NB_PH'(OS - 1);

  if (NBF_INPUT > NB_INPUT || (1 << NB_PH) != OS || OS < 2) begin : g_param_check
    $error("rx_phase_sync_slicer: bad NBF_INPUT/OS parameter");
  end

  typedef enum logic {ACQ, LOCK} state_t;

  state_t                     state_q, state_d;
  logic [NB_PH-1:0]           cnt_q, cnt_d;
  logic [LOG2_WIN-1:0]        sym_q, sym_d;
  logic [NB_PH-1:0]           phase_est_q, phase_est_d;
  logic [NB_PH-1:0]           phase_app_q, phase_app_d;
  logic [NB_ACC-1:0]          acc_q [OS];
  logic [NB_ACC-1:0]          acc_d [OS];
  logic [NB_ACC-1:0]          acc_incl [OS];
  logic                       valid_q, valid_d;
  logic signed [NB_INPUT-1:0] sym_i_q, sym_i_d, sym_q_q, sym_q_d;
  logic                       bit_i_q, bit_i_d, bit_q_q, bit_q_d;

  logic                       accept, wrap, win_end;
  logic signed [NB_E-1:0]     ext_i, ext_q;
  logic [NB_E-1:0]            abs_i, abs_q, energy;
  logic [NB_PH-1:0]           best_idx;
  logic [NB_ACC-1:0]          best_val;

  // Sign-extend before negating so that |-2**(NB_INPUT-1)| is representable.
  always_comb begin
    ext_i  = {i_sample_I[NB_INPUT-1], i_sample_I};
    ext_q  = {i_sample_Q[NB_INPUT-1], i_sample_Q};
    abs_i  = ext_i[NB_E-1] ? NB_E'(-ext_i) : NB_E'(ext_i);
    abs_q  = ext_q[NB_E-1] ? NB_E'(-ext_q) : NB_E'(ext_q);
    energy = abs_i + abs_q;
  end

  assign accept  = i_enable & i_valid & i_reset;
  assign wrap    = (cnt_q == CNT_LAST);
  assign win_end = accept & wrap & (&sym_q);

  // Argmax includes the closing sample; strict compare keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = '0;
    for (int k = 0; k < OS; k++) begin
      acc_incl[k] = acc_q[k];
      if (cnt_q == k[NB_PH-1:0]) begin
        acc_incl[k] = acc_q[k] + {{(NB_ACC-NB_E){1'b0}}, energy};
      end
    end
    best_val = acc_incl[0];
    for (int k = 1; k < OS; k++) begin
      if (acc_incl[k] > best_val) begin
        best_val = acc_incl[k];
        best_idx = k[NB_PH-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sym_d       = sym_q;
    phase_est_d = phase_est_q;
    phase_app_d = phase_app_q;
    acc_d       = acc_q;
    valid_d     = 1'b0;
    sym_i_d     = sym_i_q;
    sym_q_d     = sym_q_q;
    bit_i_d     = bit_i_q;
    bit_q_d     = bit_q_q;
    if (accept) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (wrap) begin
        sym_d = sym_q + 1'b1;
      end
      for (int k = 0; k < OS; k++) begin
        acc_d[k] = win_end ? '0 : acc_incl[k];
      end
      if (win_end) begin
        phase_est_d = best_idx;
        state_d     = LOCK;
      end
      // Phase changes only at the symbol boundary so no symbol is dropped or repeated.
      if (wrap) begin
        if (i_phase_force_en) phase_app_d = i_phase_force;
        else if (win_end)     phase_app_d = best_idx;
        else                  phase_app_d = phase_est_q;
      end
      if ((cnt_q == phase_app_q) && (state_q == LOCK || i_phase_force_en)) begin
        valid_d = 1'b1;
        sym_i_d = i_sample_I;
        sym_q_d = i_sample_Q;
        bit_i_d = i_sample_I[NB_INPUT-1];
        bit_q_d = i_sample_Q[NB_INPUT-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q     <= ACQ;
      cnt_q       <= '0;
      sym_q       <= '0;
      phase_est_q <= '0;
      phase_app_q <= '0;
      for (int k = 0; k < OS; k++) acc_q[k] <= '0;
      valid_q     <= 1'b0;
      sym_i_q     <= '0;
      sym_q_q     <= '0;
      bit_i_q     <= 1'b0;
      bit_q_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sym_q       <= sym_d;
      phase_est_q <= phase_est_d;
      phase_app_q <= phase_app_d;
      for (int k = 0; k < OS; k++) acc_q[k] <= acc_d[k];
      valid_q     <= valid_d;
      sym_i_q     <= sym_i_d;
      sym_q_q     <= sym_q_d;
      bit_i_q     <= bit_i_d;
      bit_q_q     <= bit_q_d;
    end
  end

  assign o_phase  = phase_app_q;
  assign o_locked = (state_q == LOCK);
  assign o_valid  = valid_q;
  assign o_sym_I  = sym_i_q;
  assign o_sym_Q  = sym_q_q;
  assign o_bit_I  = bit_i_q;
  assign o_bit_Q  = bit_q_q;

endmodule

// File: tb/tb_rx_phase_sync_slicer.sv
// Scoreboard bench for rx_phase_sync_slicer: directed stimulus pushes expected symbols,
// a negedge monitor pops and compares on every o_valid.
module tb_rx_phase_sync_slicer;

  logic              clock = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_enable = 1'b0;
  logic              i_valid = 1'b0;
  logic signed [7:0] i_sample_I = '0;
  logic signed [7:0] i_sample_Q = '0;
  logic              i_phase_force_en = 1'b0;
  logic [1:0]        i_phase_force = '0;
  logic [1:0]        o_phase;
  logic              o_locked;
  logic              o_valid;
  logic signed [7:0] o_sym_I;
  logic signed [7:0] o_sym_Q;
  logic              o_bit_I;
  logic              o_bit_Q;

  rx_phase_sync_slicer dut (
    .clock            (clock),
    .i_reset          (i_reset),
    .i_enable         (i_enable),
    .i_valid          (i_valid),
    .i_sample_I       (i_sample_I),
    .i_sample_Q       (i_sample_Q),
    .i_phase_force_en (i_phase_force_en),
    .i_phase_force    (i_phase_force),
    .o_phase          (o_phase),
    .o_locked         (o_locked),
    .o_valid          (o_valid),
    .o_sym_I          (o_sym_I),
    .o_sym_Q          (o_sym_Q),
    .o_bit_I          (o_bit_I),
    .o_bit_Q          (o_bit_Q)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q [$];

  // Reference state: sample phase, symbol index, lock, applied/estimated phase.
  bit [1:0] cnt_m, app_m, est_m, next_est, force_m;
  int       sym_m;
  bit       locked_m, force_en_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clock);
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {14'd0, o_sym_I[1:0], o_bit_I, o_bit_Q}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("symbol", {14'd0, o_sym_I, o_sym_Q, o_bit_I, o_bit_Q}, {14'd0, e});
        end
      end
    end
  end

  // Caller sits 1 time unit after a posedge; inputs are taken at the next posedge.
  task automatic send(input logic signed [7:0] si, input logic signed [7:0] sq,
                      input bit v, input bit en);
    i_valid = v; i_enable = en; i_sample_I = si; i_sample_Q = sq;
    if (v && en) begin
      if (cnt_m == app_m && (locked_m || force_en_m))
        exp_q.push_back({si, sq, si[7], sq[7]});
      if (cnt_m == 2'd3) begin
        if (sym_m == 255) begin
          locked_m = 1'b1;
          est_m    = next_est;
          sym_m    = 0;
        end else begin
          sym_m++;
        end
        app_m = force_en_m ? force_m : est_m;
        cnt_m = 2'd0;
      end else begin
        cnt_m++;
      end
    end
    @(posedge clock); #1;
    i_valid = 1'b0;
  endtask

  task automatic send_pat(input int n);
    for (int k = 0; k < n; k++) begin
      if (cnt_m == 2'd2) send(8'sd100, 8'sd60, 1'b1, 1'b1);
      else               send(8'sd5, 8'sd5, 1'b1, 1'b1);
    end
  endtask

  task automatic do_reset(input int n, input bit full_check);
    i_reset = 1'b0; i_valid = 1'b1; i_enable = 1'b1;
    i_sample_I = -8'sd90; i_sample_Q = 8'sd50;
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
    end
    if (full_check) begin
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_sym",   {16'd0, o_sym_I, o_sym_Q}, 32'd0);
      chk("rst_bits",  {30'd0, o_bit_I, o_bit_Q}, 32'd0);
    end
    chk("rst_locked", {31'd0, o_locked}, 32'd0);
    chk("rst_phase",  {30'd0, o_phase}, 32'd0);
    i_reset = 1'b1; i_valid = 1'b0;
    cnt_m = 0; sym_m = 0; locked_m = 0; app_m = 0; est_m = 0;
  endtask

  initial begin
    force_en_m = 0; force_m = 0; next_est = 2;

    // Reset held 3 cycles with valid samples present, then acquisition.
    do_reset(3, 1'b1);
    send_pat(1023);
    chk("acq_not_locked", {31'd0, o_locked}, 32'd0);
    send_pat(1);
    chk("acq_locked", {31'd0, o_locked}, 32'd1);
    chk("acq_phase",  {30'd0, o_phase}, 32'd2);
    send_pat(64);

    // Slicing of negative / zero samples on the selected phase.
    while (cnt_m != 2'd2) send_pat(1);
    send(-8'sd100, 8'sd50, 1'b1, 1'b1);
    send_pat(3);
    send(8'sd0, -8'sd1, 1'b1, 1'b1);
    send_pat(1024 - (sym_m * 4 + cnt_m));
    chk("win2_phase", {30'd0, o_phase}, 32'd2);

    // Full-scale negative window: all phases tie, lowest index wins.
    next_est = 0;
    for (int k = 0; k < 1023; k++) send(-8'sd128, -8'sd128, 1'b1, 1'b1);
    chk("acc0_full",  {15'd0, dut.acc_q[0]}, 32'd65536);
    chk("acc3_part",  {15'd0, dut.acc_q[3]}, 32'd65280);
    send(-8'sd128, -8'sd128, 1'b1, 1'b1);
    chk("tie_phase", {30'd0, o_phase}, 32'd0);
    send_pat(8);

    // Forced phase 3 before lock, released after lock with estimate 2.
    do_reset(1, 1'b0);
    next_est = 2;
    force_en_m = 1; force_m = 3;
    i_phase_force_en = 1'b1; i_phase_force = 2'd3;
    send_pat(4);
    chk("force_phase", {30'd0, o_phase}, 32'd3);
    send_pat(1020);
    chk("force_locked", {31'd0, o_locked}, 32'd1);
    chk("force_hold",   {30'd0, o_phase}, 32'd3);
    send_pat(2);
    force_en_m = 0; i_phase_force_en = 1'b0;
    send_pat(1);
    chk("release_wait", {30'd0, o_phase}, 32'd3);
    send_pat(1);
    chk("release_phase", {30'd0, o_phase}, 32'd2);
    send_pat(8);

    // Gaps: alternating valid, then enable low with strong samples that must be ignored.
    for (int k = 0; k < 40; k++) begin
      send_pat(1);
      send(8'sd7, 8'sd7, 1'b0, 1'b1);
    end
    for (int k = 0; k < 7; k++) send(-8'sd128, 8'sd127, 1'b1, 1'b0);
    send_pat(20);

    // One-cycle reset mid-window: full reacquisition needed.
    do_reset(1, 1'b0);
    send_pat(1023);
    chk("reacq_not_locked", {31'd0, o_locked}, 32'd0);
    send_pat(1);
    chk("reacq_locked", {31'd0, o_locked}, 32'd1);
    chk("reacq_phase",  {30'd0, o_phase}, 32'd2);
    send_pat(16);

    repeat (4) @(posedge clock);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
